// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing (a - b - bin) mod 2^WIDTH, LSB first.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - asynchronous active-high reset
//   start - begin a subtraction (accepted only in IDLE)
//   a, b  - minuend and subtrahend, captured when start is accepted
//   bin   - borrow-in, captured when start is accepted
//   diff  - registered result, updated only on completion
//   bout  - registered final borrow-out, updated only on completion
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when diff/bout hold a new result
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, br_next, last;

    assign d       = op_a[0] ^ op_b[0] ^ br;
    assign br_next = (~op_a[0] & op_b[0]) | (~(op_a[0] ^ op_b[0]) & br);
    assign last    = cnt == LAST;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN: begin
                busy       = 1'b1;
                state_next = last ? DONE : RUN;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (state == IDLE && start) begin
            op_a <= a;
            op_b <= b;
            br   <= bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            op_a <= op_a >> 1;
            op_b <= op_b >> 1;
            br   <= br_next;
            res  <= {d, res[WIDTH-1:1]};
            // the counter parks on the last index instead of wrapping; it is cleared on the next start
            if (last) begin
                diff <= {d, res[WIDTH-1:1]};
                bout <= br_next;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule
